count_scheduler: RTL and testbench
==================================

COUNT_SCHEDULER -- requirements
Module: count_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning counter and data width in bits.
REQ-002 SHALL have parameter NUM_REQ, fixed at 2, meaning the number of command requesters.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: the reset; it is asynchronous and active-high.
REQ-005 SHALL have port run_en, input, 1 bit: enables free-run increment.
REQ-006 SHALL have port cmd_valid, input, NUM_REQ bits: per-requester command valid.
REQ-007 SHALL have port cmd_ready, output, NUM_REQ bits: per-requester command accept.
REQ-008 SHALL have port cmd_op, input, NUM_REQ x 2 bits: per-requester opcode.
REQ-009 SHALL have port cmd_data, input, NUM_REQ x WIDTH bits: per-requester operand.
REQ-010 SHALL have port rsp_valid, output, NUM_REQ bits: per-requester one-cycle completion pulse.
REQ-011 SHALL have port rsp_count, output, WIDTH bits: counter value accompanying rsp_valid.
REQ-012 SHALL have port count, output, WIDTH bits: current counter value, driven to pads.
REQ-013 SHALL have port wrap, output, 1 bit: one-cycle pulse when the counter wraps.
REQ-014 SHALL have port busy, output, 1 bit: high when the FSM is not in IDLE.

Function
REQ-015 SHALL implement the opcodes 0 READ (counter unchanged), 1 CLEAR (count=0), 2 LOAD (count=data) and 3 ADD (count=count+data mod 2^WIDTH).
REQ-016 SHALL implement an FSM with states IDLE, EXEC and RESP, with transitions IDLE->EXEC on accept, EXEC->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-017 SHALL assert cmd_ready only in IDLE, combinationally, and only to the single arbitration winner among the asserted cmd_valid bits.
REQ-018 SHALL use round-robin arbitration: a pointer names the preferred requester, and after each accept the pointer moves to the requester that was not granted.
REQ-019 SHALL register grant, op and data on the accepting edge (cycle N).
REQ-020 SHALL update count at the end of EXEC (edge N+1).
REQ-021 SHALL assert rsp_valid[grant] for exactly one cycle during RESP (cycle N+2), with rsp_count equal to the updated count.
REQ-022 SHALL drive rsp_valid to 0 and rsp_count to 0 outside RESP.
REQ-023 SHALL limit throughput to one command per 3 cycles; a requester holding cmd_valid high during EXEC and RESP is not accepted until the next IDLE.
REQ-024 SHALL increment count by 1 on each cycle where the FSM is in IDLE, run_en=1, and no command is accepted in that cycle.
REQ-025 SHALL give command accept priority over free-run when both occur in the same cycle: no increment occurs in that cycle.
REQ-026 SHALL hold count in EXEC and RESP except for the operation's own update.
REQ-027 SHALL pulse wrap for one cycle, coincident with the new count, when a free-run increment goes from 2^WIDTH-1 to 0 or an ADD produces a carry out.
REQ-028 SHALL never assert wrap for LOAD or CLEAR.
REQ-029 SHALL treat ADD with data=0 as leaving count unchanged, with no wrap.

Reset
REQ-030 SHALL apply, while rst=1, asynchronously: state=IDLE, count=0, rr pointer=requester 0, rsp_valid=0, rsp_count=0, wrap=0, busy=0, cmd_ready=0.
REQ-031 SHALL, on reset asserted in EXEC or RESP, abort the in-flight command: no rsp_valid is issued and its update is discarded if not yet applied.
REQ-032 SHALL make the first accept possible on the first rising edge after rst deasserts.

Structure
REQ-033 SHALL place the opcode enum (OP_READ, OP_CLEAR, OP_LOAD, OP_ADD) and the state enum in package count_scheduler_pkg.
REQ-034 SHALL implement arbitration in sub-module rr_arbiter, which has request and pointer inputs and a one-hot grant output and is purely combinational.

Verification
REQ-035 SHALL cover: WIDTH=8, req0 LOAD 0xFE, run_en=0 -> rsp_valid[0] two cycles after accept, rsp_count=0xFE, count=0xFE.
REQ-036 SHALL cover: count=0xFE, run_en=1, no commands -> 0xFF, then 0x00 with wrap=1 for one cycle, then 0x01.
REQ-037 SHALL cover: both requesters hold ADD 1 continuously from reset -> accepts alternate 0,1,0,1 with one accept per 3 cycles, and count increases by 1 per command.
REQ-038 SHALL cover: count=0xF0, ADD 0x20 -> count=0x10, wrap=1; then ADD 0x00 -> count=0x10, wrap=0.
REQ-039 SHALL cover: run_en=1 and a command accepted in the same cycle -> no increment in that cycle; count is held during EXEC and RESP.
REQ-040 SHALL cover: rst pulsed during EXEC of LOAD 0x55 -> count=0, no rsp_valid, and the next accept grants requester 0.

Source files
------------

// File: rtl/count_scheduler_pkg.sv
// rtl/count_scheduler_pkg.sv - shared opcode and FSM state types for the count scheduler
package count_scheduler_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_READ  = 2'd0,
        OP_CLEAR = 2'd1,
        OP_LOAD  = 2'd2,
        OP_ADD   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/count_scheduler_rr_arbiter.sv
// rtl/count_scheduler_rr_arbiter.sv - combinational round-robin arbiter with one-hot grant
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PW      = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic found;

    // Walk requesters starting at the pointer and grant the first one asserted
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req[j] && (j == ((int'(ptr) + i) % NUM_REQ))) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/count_scheduler.sv
// rtl/count_scheduler.sv - free-running counter with arbitrated READ/CLEAR/LOAD/ADD commands
module count_scheduler
    import count_scheduler_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run_en,
    input  logic [NUM_REQ-1:0]       cmd_valid,
    output logic [NUM_REQ-1:0]       cmd_ready,
    input  logic [NUM_REQ*OP_W-1:0]  cmd_op,
    input  logic [NUM_REQ*WIDTH-1:0] cmd_data,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_count,
    output logic [WIDTH-1:0]         count,
    output logic                     wrap,
    output logic                     busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        grant_q, grant_d;
    op_e                  op_q, op_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic [WIDTH-1:0]     rsp_count_q, rsp_count_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic                 wrap_q, wrap_d;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [PW-1:0]        arb_idx;
    logic [OP_W-1:0]      sel_op;
    logic [WIDTH-1:0]     sel_data;
    logic                 accept;
    logic [WIDTH:0]       add_sum;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_arb (
        .req   (cmd_valid),
        .ptr   (ptr_q),
        .grant (arb_grant)
    );

    // Ready is withheld during reset even though the state already reads IDLE
    assign cmd_ready = (state_q == IDLE && !rst) ? arb_grant : '0;
    assign accept    = |(cmd_valid & cmd_ready);
    assign add_sum   = {1'b0, count_q} + {1'b0, data_q};

    assign count     = count_q;
    assign wrap      = wrap_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_count = rsp_count_q;
    assign busy      = (state_q != IDLE);

    // Select the winning requester's index, opcode and operand
    always_comb begin
        arb_idx  = '0;
        sel_op   = '0;
        sel_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (arb_grant[j]) begin
                arb_idx  = PW'(j);
                sel_op   = cmd_op[j*OP_W +: OP_W];
                sel_data = cmd_data[j*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state: accept beats free-run in IDLE, the op lands leaving EXEC, RESP just reports
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        op_d        = op_q;
        data_d      = data_q;
        count_d     = count_q;
        wrap_d      = 1'b0;
        rsp_valid_d = '0;
        rsp_count_d = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXEC;
                    grant_d = arb_idx;
                    op_d    = op_e'(sel_op);
                    data_d  = sel_data;
                    ptr_d   = (arb_idx == PW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                end else if (run_en) begin
                    count_d = count_q + 1'b1;
                    wrap_d  = &count_q;
                end
            end
            EXEC: begin
                state_d = RESP;
                unique case (op_q)
                    OP_READ:  count_d = count_q;
                    OP_CLEAR: count_d = '0;
                    OP_LOAD:  count_d = data_q;
                    OP_ADD: begin
                        count_d = add_sum[WIDTH-1:0];
                        wrap_d  = add_sum[WIDTH];
                    end
                endcase
                rsp_count_d = count_d;
                for (int j = 0; j < NUM_REQ; j++) begin
                    rsp_valid_d[j] = (grant_q == PW'(j));
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight command
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            op_q        <= OP_READ;
            data_q      <= '0;
            count_q     <= '0;
            wrap_q      <= 1'b0;
            rsp_valid_q <= '0;
            rsp_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            op_q        <= op_d;
            data_q      <= data_d;
            count_q     <= count_d;
            wrap_q      <= wrap_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_count_q <= rsp_count_d;
        end
    end

endmodule

// File: tb/tb_count_scheduler.sv
// tb/tb_count_scheduler.sv - randomized self-checking bench with a cycle-level reference model
module tb_count_scheduler;
    import count_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_en;
    logic [1:0]  cmd_valid;
    logic [1:0]  cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_data;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_count;
    logic [7:0]  count;
    logic        wrap;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase 0 idle, 1 executing, 2 responding
    int   m_count;
    int   m_phase;
    logic m_ptr;
    int   m_grant;
    int   m_op;
    int   m_data;
    int   m_wrap;
    int   m_rsp_valid;
    int   m_rsp_count;

    count_scheduler #(.WIDTH(8), .NUM_REQ(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .run_en    (run_en),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_count (rsp_count),
        .count     (count),
        .wrap      (wrap),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_count     = 0;
        m_phase     = 0;
        m_ptr       = 1'b0;
        m_grant     = 0;
        m_op        = 0;
        m_data      = 0;
        m_wrap      = 0;
        m_rsp_valid = 0;
        m_rsp_count = 0;
    endtask

    task automatic check_outputs();
        check("count",     32'(count),     32'(m_count));
        check("wrap",      32'(wrap),      32'(m_wrap));
        check("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
        check("rsp_count", 32'(rsp_count), 32'(m_rsp_count));
        check("busy",      32'(busy),      (m_phase != 0) ? 32'd1 : 32'd0);
    endtask

    // One clock cycle: starts and ends at a falling edge
    task automatic step(input logic run, input logic [1:0] v, input logic [1:0] op0,
                        input logic [1:0] op1, input logic [7:0] d0, input logic [7:0] d1);
        int w;
        int s;
        run_en    = run;
        cmd_valid = v;
        cmd_op    = {op1, op0};
        cmd_data  = {d1, d0};
        #1;
        w = -1;
        if (m_phase == 0) begin
            if (v[m_ptr])       w = m_ptr ? 1 : 0;
            else if (v[!m_ptr]) w = m_ptr ? 0 : 1;
        end
        check("cmd_ready", 32'(cmd_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
        @(posedge clk);
        m_wrap      = 0;
        m_rsp_valid = 0;
        m_rsp_count = 0;
        case (m_phase)
            0: begin
                if (w >= 0) begin
                    m_grant = w;
                    m_op    = (w == 1) ? int'(op1) : int'(op0);
                    m_data  = (w == 1) ? int'(d1) : int'(d0);
                    m_ptr   = (w == 0);
                    m_phase = 1;
                end else if (run) begin
                    m_wrap  = (m_count == 255) ? 1 : 0;
                    m_count = (m_count + 1) % 256;
                end
            end
            1: begin
                case (m_op)
                    1: m_count = 0;
                    2: m_count = m_data;
                    3: begin
                        s       = m_count + m_data;
                        m_wrap  = (s > 255) ? 1 : 0;
                        m_count = s % 256;
                    end
                    default: ;
                endcase
                m_rsp_valid = 1 << m_grant;
                m_rsp_count = m_count;
                m_phase     = 2;
            end
            default: m_phase = 0;
        endcase
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    // Asynchronous reset pulse spanning one rising edge; starts and ends at a falling edge
    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 2'b11;
        run_en    = 1'b1;
        #1;
        check("rst_count",     32'(count),     32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_wrap",      32'(wrap),      32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_count",     32'(count),     32'd0);
        check("rst_hold_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_hold_rsp_count", 32'(rsp_count), 32'd0);
        @(negedge clk);
        cmd_valid = 2'b00;
        run_en    = 1'b0;
        rst       = 1'b0;
        model_reset();
    endtask

    initial begin
        rst       = 1'b1;
        run_en    = 1'b0;
        cmd_valid = 2'b00;
        cmd_op    = '0;
        cmd_data  = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // LOAD 0xFE from requester 0, response two cycles after accept
        step(1'b0, 2'b01, OP_LOAD, OP_READ, 8'hFE, 8'h00);
        step(1'b0, 2'b00, OP_READ, OP_READ, 8'h00, 8'h00);
        step(1'b0, 2'b00, OP_READ, OP_READ, 8'h00, 8'h00);
        check("load_fe_count", 32'(count), 32'hFE);

        // Free-run across the wrap point
        repeat (3) step(1'b1, 2'b00, OP_READ, OP_READ, 8'h00, 8'h00);
        check("freerun_after_wrap", 32'(count), 32'h01);

        // ADD with carry, then ADD zero
        step(1'b0, 2'b10, OP_READ, OP_LOAD, 8'h00, 8'hF0);
        repeat (2) step(1'b0, 2'b00, OP_READ, OP_READ, 8'h00, 8'h00);
        step(1'b0, 2'b01, OP_ADD, OP_READ, 8'h20, 8'h00);
        repeat (2) step(1'b0, 2'b00, OP_READ, OP_READ, 8'h00, 8'h00);
        check("add_carry_count", 32'(count), 32'h10);
        step(1'b0, 2'b10, OP_READ, OP_ADD, 8'h00, 8'h00);
        repeat (2) step(1'b0, 2'b00, OP_READ, OP_READ, 8'h00, 8'h00);

        // Accept beats free-run; count held through EXEC and RESP
        step(1'b1, 2'b01, OP_READ, OP_READ, 8'h00, 8'h00);
        repeat (3) step(1'b1, 2'b00, OP_READ, OP_READ, 8'h00, 8'h00);

        // Both requesters hold ADD 1 from reset: alternate grants every third cycle
        do_reset();
        repeat (12) step(1'b0, 2'b11, OP_ADD, OP_ADD, 8'h01, 8'h01);
        check("alt_add_count", 32'(count), 32'd4);

        // Reset during EXEC of LOAD 0x55 discards it; next accept goes to requester 0
        step(1'b0, 2'b01, OP_LOAD, OP_READ, 8'h55, 8'h00);
        do_reset();
        step(1'b0, 2'b11, OP_READ, OP_READ, 8'h00, 8'h00);
        repeat (2) step(1'b0, 2'b00, OP_READ, OP_READ, 8'h00, 8'h00);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            logic [7:0] d0;
            logic [7:0] d1;
            d0 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            d1 = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            if ($urandom_range(0, 59) == 0) do_reset();
            else step(1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), d0, d1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
